// File: rtl/pipe_seg_fifo_if.sv
// Handshake bundle between two pipeline stages around a pipe_seg_fifo.
// master = upstream/downstream environment, slave = the buffer itself.
interface pipe_seg_fifo_if #(
  parameter int DW = 64,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) ();
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_is_branch;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_bd;
  logic          out_is_branch;
  logic [CW-1:0] count;

  modport master (
    output in_valid, in_data, in_is_branch, out_ready,
    input  in_ready, out_valid, out_data, out_bd, out_is_branch, count
  );

  modport slave (
    input  in_valid, in_data, in_is_branch, out_ready,
    output in_ready, out_valid, out_data, out_bd, out_is_branch, count
  );
endinterface

// File: rtl/pipe_seg_fifo.sv
// Pipeline-segment valid/ready buffer with per-entry branch-delay-slot tagging
// and a synchronous flush for exceptions/redirects.
module pipe_seg_fifo #(
  parameter int DW = 64,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush,
  pipe_seg_fifo_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DW-1:0]    data_q [DEPTH];
  logic [DW-1:0]    data_d [DEPTH];
  logic [DEPTH-1:0] br_q, br_d;
  logic [DEPTH-1:0] bd_q, bd_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             last_branch_q, last_branch_d;
  logic             push, pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Handshake outputs depend on registered occupancy only, so out_ready never
  // reaches in_ready combinationally.
  assign bus.in_ready      = (count_q != FULL_CNT);
  assign bus.out_valid     = (count_q != '0);
  assign bus.out_data      = data_q[rd_ptr_q];
  assign bus.out_bd        = bd_q[rd_ptr_q];
  assign bus.out_is_branch = br_q[rd_ptr_q];
  assign bus.count         = count_q;

  assign push = bus.in_valid  & bus.in_ready  & ~flush;
  assign pop  = bus.out_valid & bus.out_ready & ~flush;

  always_comb begin
    data_d        = data_q;
    br_d          = br_q;
    bd_d          = bd_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    last_branch_d = last_branch_q;

    if (push) begin
      data_d[wr_ptr_q] = bus.in_data;
      br_d[wr_ptr_q]   = bus.in_is_branch;
      bd_d[wr_ptr_q]   = last_branch_q;
      wr_ptr_d         = next_ptr(wr_ptr_q);
      last_branch_d    = bus.in_is_branch;
    end

    if (pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Storage is left stale on flush; out_valid=0 hides it.
    if (flush) begin
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      count_d       = '0;
      last_branch_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
      br_q          <= '0;
      bd_q          <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      last_branch_q <= 1'b0;
    end else begin
      data_q        <= data_d;
      br_q          <= br_d;
      bd_q          <= bd_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      last_branch_q <= last_branch_d;
    end
  end
endmodule
